fir_filter_pipe: RTL and testbench

- Parametrised, pipelined direct-form FIR filter. Successor to the fixed 4-tap power-of-two filter.
- Adds:
  - configurable tap count and data/coefficient widths;
  - a runtime-writable coefficient bank;
  - valid-qualified input and output;
  - registered multiply and accumulate stages;
  - rounding, output saturation and a delay-line clear.
- Sits in the sample datapath between the ADC-side capture logic and downstream DSP stages.

---
 rtl/fir_pkg.sv | 25 ++
 rtl/fir_round_sat.sv | 46 ++++
 rtl/fir_filter_pipe.sv | 114 +++++++++++
 tb/tb_fir_filter_pipe.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared sizing and rounding helpers for the pipelined FIR filter.
package fir_pkg;

    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    // Q(frac_w) defaults: 1, 1/2, 1/4, ... down to 2^-frac_w, then zero.
    function automatic int default_coef(input int k, input int frac_w);
        return (k <= frac_w) ? (1 << (frac_w - k)) : 0;
    endfunction

    function automatic longint round_bias(input int frac_w);
        return (frac_w > 0) ? (longint'(1) << (frac_w - 1)) : longint'(0);
    endfunction

    function automatic longint sat_max(input int data_w);
        return (longint'(1) << (data_w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int data_w);
        return -(longint'(1) << (data_w - 1));
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up, arithmetic shift and clamp of the accumulator to the output width.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18,
    parameter int FRAC_W = 6
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] y_next,
    output logic                     sat_next
);
    // One guard bit so adding the rounding bias can never wrap.
    localparam int EXT_W = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] BIAS  = EXT_W'(round_bias(FRAC_W));
    localparam logic signed [EXT_W-1:0] Y_MAX = EXT_W'(sat_max(DATA_W));
    localparam logic signed [EXT_W-1:0] Y_MIN = EXT_W'(sat_min(DATA_W));

    logic signed [EXT_W-1:0] rnd;

    function automatic logic signed [EXT_W-1:0] round_half_up(input logic signed [ACC_W-1:0] a);
        logic signed [EXT_W-1:0] t;
        t = EXT_W'(a) + BIAS;
        return t >>> FRAC_W;
    endfunction

    function automatic logic is_clipped(input logic signed [EXT_W-1:0] r);
        return (r > Y_MAX) || (r < Y_MIN);
    endfunction

    function automatic logic signed [DATA_W-1:0] clamp(input logic signed [EXT_W-1:0] r);
        if (r > Y_MAX)
            return Y_MAX[DATA_W-1:0];
        else if (r < Y_MIN)
            return Y_MIN[DATA_W-1:0];
        else
            return r[DATA_W-1:0];
    endfunction

    always_comb begin
        rnd      = round_half_up(acc);
        y_next   = clamp(rnd);
        sat_next = is_clipped(rnd);
    end

endmodule

// File: rtl/fir_filter_pipe.sv
// Pipelined direct-form FIR: registered products, registered rounded/saturated sum,
// runtime-writable coefficient bank and a synchronous delay-line clear.
module fir_filter_pipe
    import fir_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 4,
    parameter int FRAC_W = 6,
    parameter int ADDR_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] x,
    input  logic                     coef_we,
    input  logic [ADDR_W-1:0]        coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] y,
    output logic                     sat
);
    localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS);
    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [COEF_W-1:0] coef    [TAPS];
    logic signed [DATA_W-1:0] dly_p0  [TAPS-1];
    logic signed [DATA_W-1:0] tap_p0  [TAPS];
    logic signed [PROD_W-1:0] prod_p1 [TAPS];
    logic                     vld_p1;
    logic signed [ACC_W-1:0]  acc_p1;
    logic signed [DATA_W-1:0] y_next;
    logic                     sat_next;

    // Full-width signed product: -2^(DATA_W-1) * -2^(COEF_W-1) still fits.
    function automatic logic signed [PROD_W-1:0] mul(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [COEF_W-1:0] b);
        return PROD_W'(a) * PROD_W'(b);
    endfunction

    always_comb begin
        tap_p0[0] = x;
        for (int k = 1; k < TAPS; k++)
            tap_p0[k] = dly_p0[k-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < TAPS; k++)
                coef[k] <= COEF_W'(default_coef(k, FRAC_W));
        end else if (coef_we) begin
            for (int k = 0; k < TAPS; k++)
                if (32'(coef_addr) == k)
                    coef[k] <= coef_wdata;
        end
    end

    // Stage 0 -> 1: delay line shift and tap multiplies, both only on accepted samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < TAPS-1; k++)
                dly_p0[k] <= '0;
            for (int k = 0; k < TAPS; k++)
                prod_p1[k] <= '0;
            vld_p1 <= 1'b0;
        end else if (clr) begin
            for (int k = 0; k < TAPS-1; k++)
                dly_p0[k] <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                dly_p0[0] <= x;
                for (int k = 1; k < TAPS-1; k++)
                    dly_p0[k] <= dly_p0[k-1];
                for (int k = 0; k < TAPS; k++)
                    prod_p1[k] <= mul(tap_p0[k], coef[k]);
            end
        end
    end

    always_comb begin
        acc_p1 = '0;
        for (int k = 0; k < TAPS; k++)
            acc_p1 = acc_p1 + ACC_W'(prod_p1[k]);
    end

    fir_round_sat #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .FRAC_W (FRAC_W)
    ) u_round_sat (
        .acc      (acc_p1),
        .y_next   (y_next),
        .sat_next (sat_next)
    );

    // Stage 1 -> 2: output register; y and sat hold across bubbles and clears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            sat       <= 1'b0;
        end else begin
            out_valid <= vld_p1 && !clr;
            if (vld_p1 && !clr) begin
                y   <= y_next;
                sat <= sat_next;
            end
        end
    end

endmodule

// File: tb/tb_fir_filter_pipe.sv
// Scoreboard bench for fir_filter_pipe: directed samples push hand-computed results, a monitor checks them.
module tb_fir_filter_pipe;
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int TAPS   = 4;
    localparam int FRAC_W = 6;
    localparam int ADDR_W = 2;

    logic                     clk;
    logic                     rst;
    logic                     clr;
    logic                     in_valid;
    logic signed [DATA_W-1:0] x;
    logic                     coef_we;
    logic [ADDR_W-1:0]        coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     out_valid;
    logic signed [DATA_W-1:0] y;
    logic                     sat;

    typedef struct {
        int y;
        int s;
        int due;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   mon_due;
    exp_t mon_e;

    fir_filter_pipe #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .TAPS   (TAPS),
        .FRAC_W (FRAC_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .x          (x),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .out_valid  (out_valid),
        .y          (y),
        .sat        (sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: an output is due exactly two edges after its sample was accepted.
    always @(negedge clk) begin
        if (rst) begin
            mon_due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            if (out_valid || mon_due) begin
                check("out_valid", int'(out_valid), int'(mon_due));
                if (mon_due) begin
                    mon_e = exp_q.pop_front();
                    if (out_valid) begin
                        check("y", int'(y), mon_e.y);
                        check("sat", int'(sat), mon_e.s);
                    end
                end
            end
        end
    end

    task automatic push_exp(input int ey, input int es);
        exp_t e;
        e.y   = ey;
        e.s   = es;
        e.due = cyc + 2;
        exp_q.push_back(e);
    endtask

    task automatic feed(input int xv);
        x        = DATA_W'(xv);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x        = '0;
    endtask

    task automatic send(input int xv, input int ey, input int es);
        push_exp(ey, es);
        feed(xv);
    endtask

    task automatic send_wr(input int xv, input int ey, input int es, input int addr, input int val);
        coef_we    = 1'b1;
        coef_addr  = ADDR_W'(addr);
        coef_wdata = COEF_W'(val);
        push_exp(ey, es);
        feed(xv);
        coef_we = 1'b0;
    endtask

    task automatic wr_coef(input int addr, input int val);
        coef_we    = 1'b1;
        coef_addr  = ADDR_W'(addr);
        coef_wdata = COEF_W'(val);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_y"}, int'(y), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_sat"}, int'(sat), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        clr        = 1'b0;
        in_valid   = 1'b0;
        x          = '0;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        #2 rst = 1'b0;
        #1 check_cleared("reset");
        idle(2);
        rst = 1'b1;
        idle(1);

        // Impulse through default coefficients 1, 1/2, 1/4, 1/8.
        send(64, 64, 0); send(0, 32, 0); send(0, 16, 0); send(0, 8, 0); send(0, 0, 0);

        // Positive then negative saturation, then flush the negative history.
        send(127, 127, 0);
        for (int i = 0; i < 5; i++) send(127, 127, 1);
        send(-128, -17, 0);
        for (int i = 0; i < 5; i++) send(-128, -128, 1);
        send(0, -112, 0); send(0, -48, 0); send(0, -16, 0); send(0, 0, 0);

        // Gapped input: no zeros inserted into the delay line.
        send(64, 64, 0); idle(3);
        send(0, 32, 0);  idle(3);
        send(0, 16, 0);  idle(3);
        send(0, 8, 0);   idle(3);
        send(0, 0, 0);

        // Coefficient write on a sample edge: that sample sees the old coef[1].
        send(64, 64, 0);
        send_wr(0, 32, 0, 1, -64);
        send(0, 16, 0); send(0, 8, 0); send(0, 0, 0);
        send(64, 64, 0); send(0, -64, 0); send(0, 16, 0); send(0, 8, 0); send(0, 0, 0);

        // Clear: dropped sample, history gone, coefficients and y kept.
        send(10, 10, 0); send(20, 10, 0); send(30, 13, 0);
        idle(3);
        clr = 1'b1;
        feed(100);
        clr = 1'b0;
        check("clr_y_hold", int'(y), 13);
        check("clr_sat_hold", int'(sat), 0);
        check("clr_out_valid", int'(out_valid), 0);
        idle(2);
        send(64, 64, 0); send(0, -64, 0); send(0, 16, 0); send(0, 8, 0); send(0, 0, 0);

        // Reset mid-stream: in-flight samples lost, coefficients back to defaults.
        send(-128, -128, 0);
        idle(2);
        feed(50);
        feed(50);
        rst = 1'b0;
        #1 check_cleared("midreset");
        exp_q.delete();
        idle(2);
        rst = 1'b1;
        idle(2);
        send(64, 64, 0); send(0, 32, 0); send(0, 16, 0); send(0, 8, 0); send(0, 0, 0);

        // Rounding half up: 1.5 -> 2, -1.5 -> -1.
        wr_coef(0, 32);
        send(3, 2, 0); send(0, 2, 0); send(0, 1, 0); send(0, 0, 0); send(0, 0, 0);
        send(-3, -1, 0); send(0, -1, 0); send(0, -1, 0); send(0, 0, 0); send(0, 0, 0);

        // Most negative sample times most negative coefficient.
        wr_coef(0, -128);
        send(-128, 127, 1); send(0, -64, 0); send(0, -32, 0); send(0, -16, 0); send(0, 0, 0);

        idle(6);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
